// File: rtl/mac_stream_feeder.sv
// Stream sequencer feeding the 16-lane multiply/adder-tree MAC and collecting its results.
// Optional STALL_CNT_EN adds a saturating count of starved RUN cycles on stall_cycles.
module mac_stream_feeder #(
    parameter int unsigned N       = 16,
    parameter int unsigned CHUNK_W = 8,
    parameter int unsigned OUT_W   = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CHUNK_W-1:0]  num_chunks,
    input  logic [OUT_W-1:0]    num_outputs,
    input  logic [16*N-1:0]     in_act,
    input  logic [16*N-1:0]     in_wgt,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [16*N-1:0]     A,
    output logic [16*N-1:0]     B,
    output logic                load_sig,
    input  logic [15:0]         tree_out,
    output logic [15:0]         res_data,
    output logic                res_valid,
    output logic                busy,
`ifdef STALL_CNT_EN
    output logic                done,
    output logic [15:0]         stall_cycles
`else
    output logic                done
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

    localparam logic [CHUNK_W-1:0] OneC = CHUNK_W'(1);
    localparam logic [OUT_W-1:0]   OneO = OUT_W'(1);

    state_t             state_q, state_d;
    logic [CHUNK_W-1:0] nc_q;
    logic [OUT_W-1:0]   no_q;
    logic [CHUNK_W-1:0] chunk_cnt_q;
    logic [OUT_W-1:0]   out_issue_cnt_q;
    logic [OUT_W-1:0]   res_cnt_q;
    logic [3:0]         first_q;
    logic [3:0]         last_q;
    logic               cap_q;
    logic [16*N-1:0]    a_q, b_q;
    logic [15:0]        res_data_q;
    logic               res_valid_q;

    logic start_ok, accept, beat_first, beat_last, final_beat;

    assign start_ok   = (state_q == StIdle) && start;
    assign accept     = in_valid && in_ready;
    assign beat_first = (chunk_cnt_q == '0);
    assign beat_last  = (chunk_cnt_q == nc_q - OneC);
    assign final_beat = accept && beat_last && (out_issue_cnt_q == no_q - OneO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (num_outputs == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (final_beat) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (res_cnt_q == no_q) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // The final beat moves the FSM to DRAIN, so RUN always has beats left.
    always_comb begin
        in_ready = (state_q == StRun);
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nc_q            <= '0;
            no_q            <= '0;
            chunk_cnt_q     <= '0;
            out_issue_cnt_q <= '0;
            res_cnt_q       <= '0;
            first_q         <= '0;
            last_q          <= '0;
            cap_q           <= 1'b0;
            a_q             <= '0;
            b_q             <= '0;
            res_data_q      <= '0;
            res_valid_q     <= 1'b0;
        end else begin
            if (start_ok) begin
                nc_q            <= (num_chunks == '0) ? OneC : num_chunks;
                no_q            <= num_outputs;
                chunk_cnt_q     <= '0;
                out_issue_cnt_q <= '0;
                res_cnt_q       <= '0;
            end else begin
                if (accept) begin
                    if (beat_last) begin
                        chunk_cnt_q     <= '0;
                        out_issue_cnt_q <= out_issue_cnt_q + OneO;
                    end else begin
                        chunk_cnt_q <= chunk_cnt_q + OneC;
                    end
                end
                if (cap_q) begin
                    res_cnt_q <= res_cnt_q + OneO;
                end
            end

            a_q <= accept ? in_act : '0;
            b_q <= accept ? in_wgt : '0;

            // Stage k holds the tag of the beat presented k cycles ago.
            first_q <= {first_q[2:0], accept && beat_first};
            last_q  <= {last_q[2:0], accept && beat_last};

            // Capture at end of p+4 sees the accumulator before any same-edge reload.
            cap_q       <= last_q[3];
            res_valid_q <= cap_q;
            if (cap_q) begin
                res_data_q <= tree_out;
            end
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign load_sig  = first_q[3];
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;

`ifdef STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (start_ok) begin
            stall_q <= '0;
        end else if ((state_q == StRun) && !in_valid && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_mac_stream_feeder.sv
// Scoreboard bench for mac_stream_feeder with a behavioural MAC tree in the loop.
module tb_mac_stream_feeder;

    localparam int N = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [7:0]      num_chunks = '0;
    logic [11:0]     num_outputs = '0;
    logic [16*N-1:0] in_act = '0;
    logic [16*N-1:0] in_wgt = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [16*N-1:0] A, B;
    logic            load_sig;
    logic [15:0]     tree_out;
    logic [15:0]     res_data;
    logic            res_valid;
    logic            busy;
    logic            done;
`ifdef STALL_CNT_EN
    logic [15:0]     stall_cycles;
`endif

    mac_stream_feeder #(.N(N), .CHUNK_W(8), .OUT_W(12)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_chunks  (num_chunks),
        .num_outputs (num_outputs),
        .in_act      (in_act),
        .in_wgt      (in_wgt),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .load_sig    (load_sig),
        .tree_out    (tree_out),
        .res_data    (res_data),
        .res_valid   (res_valid),
        .busy        (busy),
`ifdef STALL_CNT_EN
        .done        (done),
        .stall_cycles(stall_cycles)
`else
        .done        (done)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } res_t;

    res_t            sb[$];
    bit              load_exp[int];
    logic [16*N-1:0] a_exp[int];
    logic [16*N-1:0] b_exp[int];

    function automatic logic [15:0] dot(input logic [16*N-1:0] a, input logic [16*N-1:0] b);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < N; i++) s = s + a[16*i+:16] * b[16*i+:16];
        return s;
    endfunction

    task automatic chk(input string nm, input logic [16*N-1:0] got, input logic [16*N-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, exp);
        end
    endtask

    // Behavioural tree: three pipeline registers then the accumulator.
    logic [15:0] f_q, g_q, y_q, acc_q;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_q <= '0; g_q <= '0; y_q <= '0; acc_q <= '0;
        end else begin
            f_q   <= dot(A, B);
            g_q   <= f_q;
            y_q   <= g_q;
            acc_q <= load_sig ? y_q : acc_q + y_q;
        end
    end
    assign tree_out = acc_q;

    always @(negedge clk) begin
        if (rst) begin
            chk("load_sig", {255'b0, load_sig}, {255'b0, load_exp.exists(cyc) ? 1'b1 : 1'b0});
            chk("A", A, a_exp.exists(cyc) ? a_exp[cyc] : '0);
            chk("B", B, b_exp.exists(cyc) ? b_exp[cyc] : '0);
            if (res_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_res_valid", 1, 0);
                end else begin
                    res_t r;
                    r = sb.pop_front();
                    chk("res_data", {240'b0, res_data}, {240'b0, r.data});
                    chk("res_cycle", cyc, r.cyc);
                end
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        start = 1'b0;
        #1;
        chk("rst_A", A, '0);
        chk("rst_B", B, '0);
        chk("rst_res_data", {240'b0, res_data}, '0);
        chk("rst_flags", {250'b0, load_sig, res_valid, done, in_ready, busy, 1'b0}, '0);
        sb.delete();
        load_exp.delete();
        a_exp.delete();
        b_exp.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // vmode: 0 continuous valid, 1 random valid, 2 repeating 1,0,0,1.
    task automatic run_job(input int nc, input int no, input int vmode, input bit ones,
                           input int abort_at, input bit midstart);
        int nce, total, beats, stalls, k0, last_k, iter, ch, exp_done, t;
        bit v;
        logic [15:0] sum;
        nce = (nc == 0) ? 1 : nc;
        total = nce * no;
        beats = 0; stalls = 0; iter = 0; sum = '0;
        @(posedge clk); #1;
        start = 1'b1;
        num_chunks = 8'(nc);
        num_outputs = 12'(no);
        k0 = cyc;
        last_k = k0;
        @(posedge clk); #1;
        start = 1'b0;
        while (beats < total && iter < 2000) begin
            if (abort_at > 0 && beats == abort_at) begin
                apply_reset();
                return;
            end
            chk("in_ready_run", {255'b0, in_ready}, 1);
            case (vmode)
                0: v = 1'b1;
                1: v = 1'($urandom_range(0, 1));
                default: v = (iter % 4 == 0) || (iter % 4 == 3);
            endcase
            for (int i = 0; i < N; i++) begin
                in_act[16*i+:16] = ones ? 16'd1 : 16'($urandom);
                in_wgt[16*i+:16] = ones ? 16'd1 : 16'($urandom);
            end
            in_valid = v;
            if (midstart && beats == 2) begin
                start = 1'b1;
                num_chunks = 8'(nc + 1);
                num_outputs = 12'(no + 3);
            end else begin
                start = 1'b0;
            end
            if (v && in_ready) begin
                a_exp[cyc + 1] = in_act;
                b_exp[cyc + 1] = in_wgt;
                ch = beats % nce;
                if (ch == 0) begin
                    load_exp[cyc + 4] = 1'b1;
                    sum = '0;
                end
                sum = sum + dot(in_act, in_wgt);
                if (ch == nce - 1) begin
                    res_t r;
                    r.data = sum;
                    r.cyc = cyc + 6;
                    sb.push_back(r);
                end
                beats++;
                last_k = cyc;
            end else if (in_ready) begin
                stalls++;
            end
            @(posedge clk); #1;
            iter++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (beats < total) chk("beat_timeout", beats, total);
        exp_done = (no == 0) ? k0 + 1 : last_k + 7;
        t = 0;
        while (!done && t < 300) begin
            chk("in_ready_drain", {255'b0, in_ready}, 0);
            @(posedge clk); #1;
            t++;
        end
        chk("done_seen", {255'b0, done}, 1);
        chk("done_cycle", cyc, exp_done);
        chk("results_left", sb.size(), 0);
`ifdef STALL_CNT_EN
        chk("stall_cycles", {240'b0, stall_cycles}, stalls);
`endif
        @(posedge clk); #1;
        chk("idle_busy", {254'b0, busy, done}, 0);
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        chk("init_A", A, '0);
        chk("init_flags", {250'b0, load_sig, res_valid, done, in_ready, busy, 1'b0}, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        run_job(2, 4, 0, 1'b0, 5, 1'b0);
        run_job(2, 1, 0, 1'b0, 0, 1'b0);
        run_job(3, 2, 0, 1'b1, 0, 1'b0);
        run_job(1, 4, 0, 1'b0, 0, 1'b0);
        run_job(2, 1, 2, 1'b0, 0, 1'b0);
        run_job(0, 0, 0, 1'b0, 0, 1'b0);
        run_job(0, 3, 1, 1'b0, 0, 1'b0);
        run_job(2, 3, 1, 1'b0, 0, 1'b1);
        for (int j = 0; j < 6; j++) begin
            run_job($urandom_range(0, 5), $urandom_range(0, 4), 1, 1'b0, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
